// File: rtl/apu_sdram_reader_pkg.sv
// Shared defaults, control-word layout and FSM encoding for the APU SDRAM reader.
package apu_pkg;

  localparam int BURST_DEF       = 8;
  localparam int FIFO_DEPTH_DEF  = 32;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_CLEAR_BIT  = 1;
  localparam int CTRL_LEN_LSB    = 16;
  localparam int CTRL_LEN_MSB    = 23;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DATA = 2'd2
  } apu_state_t;

  // A length code of zero encodes the maximum of 256 bursts.
  function automatic logic [8:0] burst_len(input logic [7:0] code);
    return (code == 8'd0) ? 9'd256 : {1'b0, code};
  endfunction

endpackage

// File: rtl/apu_sdram_reader_if.sv
// Read-only Avalon-MM bus towards the HPS f2h_sdram0 port.
interface apu_sdram_reader_if;

  logic [28:0] sdram_address;
  logic [7:0]  sdram_burstcount;
  logic        sdram_read;
  logic        sdram_waitrequest;
  logic [63:0] sdram_readdata;
  logic        sdram_readdatavalid;

  modport master (
    output sdram_address, sdram_burstcount, sdram_read,
    input  sdram_waitrequest, sdram_readdata, sdram_readdatavalid
  );

  modport slave (
    input  sdram_address, sdram_burstcount, sdram_read,
    output sdram_waitrequest, sdram_readdata, sdram_readdatavalid
  );

endinterface

// File: rtl/apu_sdram_reader_fifo.sv
// Synchronous 64-bit show-ahead FIFO; exposes its free-entry count for the burst space check.
module apu_sample_fifo #(
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [63:0]              push_data,
  input  logic                     pop,
  output logic [63:0]              head_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   free
);

  localparam int AW = $clog2(DEPTH);

  logic [63:0]   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign push_ok_s = push && (count_r != (AW+1)'(DEPTH));
  assign pop_ok_s  = pop && (count_r != '0);
  assign head_data = mem_r[rd_ptr_r];
  assign empty     = (count_r == '0);
  assign free      = (AW+1)'(DEPTH) - count_r;

  // Storage array, no reset needed since occupancy is tracked by count_r.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      count_r <= count_r + {{AW{1'b0}}, push_ok_s} - {{AW{1'b0}}, pop_ok_s};
    end
  end

endmodule

// File: rtl/apu_sdram_reader.sv
// Audio buffer fetch engine: bursts 64-bit PCM words from HPS SDRAM into a FIFO
// and hands them to the mixer one 16-bit sample per request.
module apu_sdram_reader
  import apu_pkg::*;
#(
  parameter int BURST      = BURST_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      apu_control_valid,
  input  logic [31:0]               apu_control_data,
  input  logic                      apu_buf_valid,
  input  logic [31:0]               apu_buf_data,
  apu_sdram_reader_if.master        sdram,
  input  logic                      sample_req,
  output logic [15:0]               sample_data,
  output logic                      sample_valid,
  output logic                      buf_done_irq,
  output logic                      underflow,
  output logic                      overrun,
  output logic                      busy
);

  localparam int FAW      = $clog2(FIFO_DEPTH);
  localparam int BURST_SH = $clog2(BURST);

  apu_state_t  state_r, next_state_s;

  logic        enable_r;
  logic [7:0]  len_code_r;
  logic [8:0]  cur_len_r;
  logic        clear_pend_r;
  logic        active_valid_r, pending_valid_r;
  logic [28:0] active_addr_r, pending_addr_r;
  logic [8:0]  burst_idx_r;
  logic [7:0]  beat_cnt_r;
  logic [28:0] addr_r;
  logic [1:0]  lane_r;
  logic [15:0] sample_data_r;
  logic        sample_valid_r, irq_r, underflow_r, overrun_r, busy_r;

  logic        issue_start_s, burst_end_s, buf_end_s;
  logic        act_valid_s, pend_valid_s, overrun_set_s;
  logic [28:0] act_addr_s, pend_addr_s, buf_word_s;
  logic        push_s, pop_s, fifo_empty_s;
  logic [63:0] fifo_head_s;
  logic [FAW:0] fifo_free_s;
  logic [15:0] lane_word_s;
  logic        unused_bits_s;

  assign buf_word_s    = apu_buf_data[31:3];
  assign unused_bits_s = ^{apu_control_data[31:24], apu_control_data[15:2], apu_buf_data[2:0]};

  assign push_s = (state_r == WAIT_DATA) && sdram.sdram_readdatavalid;
  assign pop_s  = sample_req && !fifo_empty_s && (lane_r == 2'd3);

  apu_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (sdram.sdram_readdata),
    .pop       (pop_s),
    .head_data (fifo_head_s),
    .empty     (fifo_empty_s),
    .free      (fifo_free_s)
  );

  // Dropping enable withdraws an unaccepted request in the same cycle.
  assign sdram.sdram_read       = (state_r == ISSUE) && enable_r;
  assign sdram.sdram_address    = addr_r;
  assign sdram.sdram_burstcount = 8'(BURST);

  assign sample_data  = sample_data_r;
  assign sample_valid = sample_valid_r;
  assign buf_done_irq = irq_r;
  assign underflow    = underflow_r;
  assign overrun      = overrun_r;
  assign busy         = busy_r;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state and burst/buffer completion decode.
  always_comb begin
    next_state_s  = state_r;
    issue_start_s = 1'b0;
    burst_end_s   = 1'b0;
    buf_end_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (enable_r && active_valid_r && (fifo_free_s >= (FAW+1)'(BURST))) begin
          next_state_s  = ISSUE;
          issue_start_s = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      ISSUE: begin
        if (!enable_r) begin
          next_state_s = IDLE;
        end else if (!sdram.sdram_waitrequest) begin
          next_state_s = WAIT_DATA;
        end else begin
          next_state_s = ISSUE;
        end
      end
      WAIT_DATA: begin
        if (sdram.sdram_readdatavalid && (beat_cnt_r == 8'(BURST - 1))) begin
          next_state_s = IDLE;
          burst_end_s  = 1'b1;
          buf_end_s    = ((burst_idx_r + 9'd1) == cur_len_r);
        end else begin
          next_state_s = WAIT_DATA;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Completion promotes pending first, so a simultaneous strobe lands in the freed slot.
  always_comb begin
    act_valid_s   = active_valid_r;
    act_addr_s    = active_addr_r;
    pend_valid_s  = pending_valid_r;
    pend_addr_s   = pending_addr_r;
    overrun_set_s = 1'b0;
    if (buf_end_s) begin
      if (pending_valid_r) begin
        act_addr_s   = pending_addr_r;
        pend_valid_s = 1'b0;
      end else begin
        act_valid_s = 1'b0;
      end
    end else begin
      act_valid_s = active_valid_r;
    end
    if (apu_buf_valid) begin
      if (!act_valid_s) begin
        act_valid_s = 1'b1;
        act_addr_s  = buf_word_s;
      end else if (!pend_valid_s) begin
        pend_valid_s = 1'b1;
        pend_addr_s  = buf_word_s;
      end else begin
        pend_addr_s   = buf_word_s;
        overrun_set_s = 1'b1;
      end
    end else begin
      overrun_set_s = 1'b0;
    end
  end

  // Control registers, buffer slots and burst bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      enable_r        <= 1'b0;
      len_code_r      <= 8'd0;
      cur_len_r       <= 9'd256;
      clear_pend_r    <= 1'b0;
      active_valid_r  <= 1'b0;
      active_addr_r   <= 29'd0;
      pending_valid_r <= 1'b0;
      pending_addr_r  <= 29'd0;
      burst_idx_r     <= 9'd0;
      beat_cnt_r      <= 8'd0;
      addr_r          <= 29'd0;
      irq_r           <= 1'b0;
      busy_r          <= 1'b0;
    end else begin
      if (apu_control_valid) begin
        enable_r   <= apu_control_data[CTRL_ENABLE_BIT];
        len_code_r <= apu_control_data[CTRL_LEN_MSB:CTRL_LEN_LSB];
      end
      clear_pend_r    <= apu_control_valid && apu_control_data[CTRL_CLEAR_BIT];
      active_valid_r  <= act_valid_s;
      active_addr_r   <= act_addr_s;
      pending_valid_r <= pend_valid_s;
      pending_addr_r  <= pend_addr_s;
      // Length is frozen when a buffer's first burst is launched.
      if (issue_start_s) begin
        addr_r <= active_addr_r + (29'(burst_idx_r) << BURST_SH);
        if (burst_idx_r == 9'd0) begin
          cur_len_r <= burst_len(len_code_r);
        end
      end
      if (push_s) begin
        beat_cnt_r <= burst_end_s ? 8'd0 : beat_cnt_r + 8'd1;
      end
      if (burst_end_s) begin
        burst_idx_r <= buf_end_s ? 9'd0 : burst_idx_r + 9'd1;
      end
      irq_r  <= buf_end_s;
      busy_r <= act_valid_s || (next_state_s != IDLE);
    end
  end

  // Lane multiplexer for the word at the FIFO head.
  always_comb begin
    lane_word_s = 16'd0;
    case (lane_r)
      2'd0:    lane_word_s = fifo_head_s[15:0];
      2'd1:    lane_word_s = fifo_head_s[31:16];
      2'd2:    lane_word_s = fifo_head_s[47:32];
      2'd3:    lane_word_s = fifo_head_s[63:48];
      default: lane_word_s = 16'd0;
    endcase
  end

  // Sample delivery; an empty FIFO answers with silence and leaves the lane alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_r         <= 2'd0;
      sample_data_r  <= 16'd0;
      sample_valid_r <= 1'b0;
    end else begin
      sample_valid_r <= sample_req;
      if (sample_req) begin
        if (!fifo_empty_s) begin
          sample_data_r <= lane_word_s;
          lane_r        <= lane_r + 2'd1;
        end else begin
          sample_data_r <= 16'd0;
        end
      end
    end
  end

  // Sticky status; a new event in the clearing cycle wins over the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      underflow_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      if (sample_req && fifo_empty_s) begin
        underflow_r <= 1'b1;
      end else if (clear_pend_r) begin
        underflow_r <= 1'b0;
      end
      if (overrun_set_s) begin
        overrun_r <= 1'b1;
      end else if (clear_pend_r) begin
        overrun_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_apu_sdram_reader.sv
// Randomized self-checking bench: Avalon slave with a transaction-level buffer model and a sample queue.
module tb_apu_sdram_reader;

  localparam int BURST = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        apu_control_valid = 1'b0;
  logic [31:0] apu_control_data  = 32'd0;
  logic        apu_buf_valid     = 1'b0;
  logic [31:0] apu_buf_data      = 32'd0;
  logic        sample_req        = 1'b0;
  logic [15:0] sample_data;
  logic        sample_valid, buf_done_irq, underflow, overrun, busy;

  apu_sdram_reader_if sdram ();

  apu_sdram_reader #(.BURST(BURST), .FIFO_DEPTH(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .apu_control_valid (apu_control_valid),
    .apu_control_data  (apu_control_data),
    .apu_buf_valid     (apu_buf_valid),
    .apu_buf_data      (apu_buf_data),
    .sdram             (sdram),
    .sample_req        (sample_req),
    .sample_data       (sample_data),
    .sample_valid      (sample_valid),
    .buf_done_irq      (buf_done_irq),
    .underflow         (underflow),
    .overrun           (overrun),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: buffer queue (front = active), burst progress, delivered samples.
  logic [28:0] slots[$];
  logic [15:0] smp_q[$];
  logic [15:0] stage_q[$];
  int          idx_m = 0, cur_len_m = 256, len_m = 256, exp_irq = 0;
  logic        exp_ov = 1'b0, exp_uf = 1'b0;

  int          irq_cnt = 0, acc_cnt = 0, stall_cnt = 0;
  logic [28:0] last_acc = 29'd0, prev_addr = 29'd0;
  int          beats_left = 0, beat_no = 0, wr_hold = 0, wr_pct = 0, gap_pct = 0;
  logic        last_beat_now = 1'b0, beat3_now = 1'b0, prev_stall = 1'b0;
  logic        count_mode = 1'b1;
  logic [15:0] pat_next = 16'd1;
  logic [63:0] beat_w;
  logic        req_prev = 1'b0;
  logic [15:0] exp_smp = 16'd0;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (buf_done_irq) irq_cnt++;
  end

  // Avalon slave: random stalls and beat gaps, address checking against the buffer model.
  initial begin
    sdram.sdram_waitrequest   = 1'b0;
    sdram.sdram_readdatavalid = 1'b0;
    sdram.sdram_readdata      = 64'd0;
    forever begin
      @(posedge clk);
      #1;
      while (stage_q.size() > 0) smp_q.push_back(stage_q.pop_front());
      sdram.sdram_readdatavalid = 1'b0;
      sdram.sdram_waitrequest   = 1'b0;
      last_beat_now = 1'b0;
      beat3_now     = 1'b0;
      if (prev_stall) begin
        check_value("stall_read", 64'(sdram.sdram_read), 64'd1);
        check_value("stall_addr", 64'(sdram.sdram_address), 64'(prev_addr));
      end
      prev_stall = 1'b0;
      if (rst) begin
        beats_left = 0;
      end else if (beats_left > 0) begin
        check_value("read_while_outstanding", 64'(sdram.sdram_read), 64'd0);
        if (int'($urandom_range(99, 0)) >= gap_pct) begin
          if (count_mode) begin
            for (int l = 0; l < 4; l++) begin
              beat_w[16*l +: 16] = pat_next;
              pat_next = pat_next + 16'd1;
            end
          end else begin
            beat_w = {$urandom, $urandom};
          end
          sdram.sdram_readdata      = beat_w;
          sdram.sdram_readdatavalid = 1'b1;
          for (int l = 0; l < 4; l++) stage_q.push_back(beat_w[16*l +: 16]);
          beats_left--;
          beat_no++;
          if (beat_no == 3) beat3_now = 1'b1;
          if (beats_left == 0) begin
            idx_m++;
            if (idx_m == cur_len_m) begin
              void'(slots.pop_front());
              idx_m = 0;
              exp_irq++;
              last_beat_now = 1'b1;
            end
          end
        end
      end else if (sdram.sdram_read) begin
        check_value("burstcount", 64'(sdram.sdram_burstcount), 64'(BURST));
        if (wr_hold > 0) begin
          wr_hold--;
          sdram.sdram_waitrequest = 1'b1;
        end else if (int'($urandom_range(99, 0)) < wr_pct) begin
          sdram.sdram_waitrequest = 1'b1;
        end
        if (sdram.sdram_waitrequest) begin
          prev_stall = 1'b1;
          prev_addr  = sdram.sdram_address;
          stall_cnt++;
        end else begin
          acc_cnt++;
          last_acc = sdram.sdram_address;
          if (idx_m == 0) cur_len_m = len_m;
          check_value("read_addr", 64'(sdram.sdram_address),
                      64'((slots.size() > 0) ? slots[0] + 29'(idx_m * BURST) : 29'h1FFF_FFFF));
          beats_left = BURST;
          beat_no    = 0;
        end
      end
    end
  end

  // One cycle; mode 0 idle, 1 random drain of available samples, 2 forced request.
  task automatic tick(input int mode);
    logic r;
    @(posedge clk);
    #2;
    if (req_prev) begin
      check_value("sample_valid", 64'(sample_valid), 64'd1);
      check_value("sample_data", 64'(sample_data), 64'(exp_smp));
    end else begin
      check_value("sample_idle", 64'(sample_valid), 64'd0);
    end
    apu_control_valid = 1'b0;
    apu_buf_valid     = 1'b0;
    r = (mode == 2) || ((mode == 1) && (smp_q.size() > 0) && ($urandom_range(1, 0) == 1));
    if (r) begin
      if (smp_q.size() > 0) begin
        exp_smp = smp_q.pop_front();
      end else begin
        exp_smp = 16'd0;
        exp_uf  = 1'b1;
      end
    end
    sample_req = r;
    req_prev   = r;
  endtask

  task automatic ctrl(input logic en, input logic clr, input int len, input int mode);
    apu_control_valid = 1'b1;
    apu_control_data  = {8'd0, 8'(len), 14'd0, clr, en};
    len_m = (len == 0) ? 256 : len;
    if (clr) begin
      exp_ov = 1'b0;
      exp_uf = 1'b0;
    end
    tick(mode);
  endtask

  task automatic buf_strobe(input logic [31:0] a, input int mode);
    apu_buf_valid = 1'b1;
    apu_buf_data  = a;
    if (slots.size() < 2) begin
      slots.push_back(a[31:3]);
    end else begin
      slots[1] = a[31:3];
      exp_ov   = 1'b1;
    end
    tick(mode);
  endtask

  task automatic wait_done(input int budget, input int mode);
    int n = 0;
    while ((slots.size() > 0 || beats_left > 0) && n < budget) begin
      tick(mode);
      n++;
    end
    check_value("wait_budget", 64'(slots.size() + beats_left), 64'd0);
    tick(mode);
    tick(mode);
    check_value("irq_count", 64'(irq_cnt), 64'(exp_irq));
    check_value("busy_idle", 64'(busy), 64'd0);
  endtask

  task automatic drain_all();
    int n = 0;
    while ((smp_q.size() > 0 || stage_q.size() > 0) && n < 2000) begin
      tick(1);
      n++;
    end
    tick(0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, i0;
    logic [31:0] ra;
    repeat (3) tick(0);
    rst = 1'b0;
    tick(0);
    check_value("rst_read", 64'(sdram.sdram_read), 64'd0);
    check_value("rst_addr", 64'(sdram.sdram_address), 64'd0);
    check_value("rst_irq", 64'(buf_done_irq), 64'd0);
    check_value("rst_underflow", 64'(underflow), 64'd0);
    check_value("rst_overrun", 64'(overrun), 64'd0);
    check_value("rst_busy", 64'(busy), 64'd0);
    check_value("rst_sample", 64'(sample_data), 64'd0);

    // Single one-burst buffer with counting lanes.
    a0 = acc_cnt; i0 = irq_cnt;
    ctrl(1'b1, 1'b0, 1, 0);
    buf_strobe(32'h1000_0000, 0);
    wait_done(300, 0);
    check_value("t1_reads", 64'(acc_cnt - a0), 64'd1);
    check_value("t1_addr", 64'(last_acc), 64'h0200_0000);
    check_value("t1_irqs", 64'(irq_cnt - i0), 64'd1);
    for (int k = 0; k < 32; k++) tick(2);
    tick(0);
    check_value("t1_underflow", 64'(underflow), 64'd0);

    // Five-cycle waitrequest stall.
    count_mode = 1'b0;
    a0 = acc_cnt; stall_cnt = 0; wr_hold = 5;
    buf_strobe(32'h2000_0040, 0);
    wait_done(300, 1);
    check_value("t2_stalls", 64'(stall_cnt), 64'd5);
    check_value("t2_reads", 64'(acc_cnt - a0), 64'd1);
    drain_all();

    // Three strobes: middle buffer is overwritten and never fetched.
    a0 = acc_cnt;
    buf_strobe(32'h0000_1000, 0);
    buf_strobe(32'h0000_2000, 0);
    buf_strobe(32'h0000_3000, 0);
    wait_done(600, 1);
    check_value("t3_overrun", 64'(overrun), 64'(exp_ov));
    check_value("t3_overrun_hi", 64'(overrun), 64'd1);
    check_value("t3_reads", 64'(acc_cnt - a0), 64'd2);
    check_value("t3_last_addr", 64'(last_acc), 64'h0000_0600);
    ctrl(1'b1, 1'b1, 1, 0);
    tick(0);
    tick(0);
    check_value("t3_overrun_clr", 64'(overrun), 64'd0);
    drain_all();

    // Underflow on an empty FIFO, then the first sample after refill.
    tick(2);
    tick(0);
    check_value("t4_underflow", 64'(underflow), 64'(exp_uf));
    check_value("t4_underflow_hi", 64'(underflow), 64'd1);
    buf_strobe(32'h0400_0008, 0);
    wait_done(300, 0);
    tick(2);
    tick(0);
    drain_all();

    // Length 2; completion of A coincides with the strobe of C.
    i0 = irq_cnt;
    ctrl(1'b1, 1'b1, 2, 0);
    buf_strobe(32'h0100_0000, 1);
    buf_strobe(32'h0200_0000, 1);
    for (int k = 0; k < 400 && !last_beat_now; k++) tick(1);
    check_value("t5_coincide", 64'(last_beat_now), 64'd1);
    buf_strobe(32'h0300_0000, 1);
    wait_done(1500, 1);
    check_value("t5_irqs", 64'(irq_cnt - i0), 64'd3);
    check_value("t5_overrun", 64'(overrun), 64'd0);
    drain_all();

    // Enable dropped on beat 3, resumed later at base+8.
    a0 = acc_cnt; i0 = irq_cnt;
    buf_strobe(32'h0800_0100, 1);
    for (int k = 0; k < 200 && !beat3_now; k++) tick(1);
    ctrl(1'b0, 1'b0, 2, 1);
    for (int k = 0; k < 40; k++) tick(1);
    check_value("t6_reads_paused", 64'(acc_cnt - a0), 64'd1);
    check_value("t6_busy", 64'(busy), 64'd1);
    ctrl(1'b1, 1'b0, 2, 1);
    wait_done(600, 1);
    check_value("t6_resume_addr", 64'(last_acc), 64'h0100_0028);
    check_value("t6_irqs", 64'(irq_cnt - i0), 64'd1);
    drain_all();

    // Randomized rounds with stalls and beat gaps.
    wr_pct = 30; gap_pct = 25;
    for (int r = 0; r < 12; r++) begin
      ctrl(1'b1, 1'b1, int'($urandom_range(3, 1)), 1);
      for (int b = 0; b < int'($urandom_range(3, 1)); b++) begin
        ra = $urandom;
        buf_strobe(ra, 1);
        repeat ($urandom_range(20, 0)) tick(1);
      end
      wait_done(3000, 1);
      drain_all();
      check_value("rnd_overrun", 64'(overrun), 64'(exp_ov));
      check_value("rnd_underflow", 64'(underflow), 64'(exp_uf));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apu_sdram_reader.md
Name: apu_sdram_reader

Overview:
- Audio-buffer fetch engine on the FPGA side of fpgame_soc.
- Consumes the SoC's apu_control and apu_buf export pulses.
- Masters the HPS f2h_sdram0 read-only Avalon-MM port to pull 64-bit words of 16-bit PCM into a local FIFO.
- Serves one sample per request to the APU mixer; raises a buffer-done interrupt into f2h_irq0 so the CPU can queue the next buffer.

Parameters:
- BURST, 8, beats per Avalon read burst (power of 2, 1..128)
- FIFO_DEPTH, 32, 64-bit entries in the sample FIFO (power of 2, >= 2*BURST)

Ports:
- clk  in  1  system clock, same clock as the SoC exports
- rst  in  1  synchronous, active-high reset
- apu_control_valid  in  1  one-cycle strobe; apu_control_data is valid
- apu_control_data  in  32  [0] enable, [1] clear status (self-clearing), [23:16] buffer length in bursts (0 means 256)
- apu_buf_valid  in  1  one-cycle strobe; apu_buf_data is valid
- apu_buf_data  in  32  byte address of next buffer, 8-byte aligned; bits [2:0] ignored
- sdram_address  out  29  word address (byte address >> 3)
- sdram_burstcount  out  8  always BURST
- sdram_read  out  1  Avalon read request
- sdram_waitrequest  in  1  Avalon stall
- sdram_readdata  in  64  read beat
- sdram_readdatavalid  in  1  beat valid
- sample_req  in  1  mixer pulls one sample
- sample_data  out  16  signed PCM sample
- sample_valid  out  1  one-cycle strobe
- buf_done_irq  out  1  one-cycle pulse; routed to an f2h_irq0 bit
- underflow  out  1  sticky status
- overrun  out  1  sticky status
- busy  out  1  an active buffer exists or a burst is in flight

Behaviour:
- Reset: all outputs 0; FSM in IDLE; FIFO empty; enable = 0; length = 256 bursts; active and pending slots empty; lane index = 0.
- Control strobe:
  - Latches enable and length.
  - Bit 1 clears underflow and overrun the following cycle.
  - A length change takes effect on the next buffer only.
- Buffer strobe:
  - If the active slot is empty, the address loads into the active slot.
  - Else if the pending slot is empty, it loads into the pending slot.
  - Else it overwrites the pending slot and sets overrun.
  - Strobes are accepted whether or not enable is set.
- FSM states:
  - IDLE -> ISSUE when enable=1, active valid, and FIFO free entries >= BURST. The free count excludes words still to arrive; only one burst is ever outstanding.
  - ISSUE: sdram_read=1 with address = active_addr + burst_idx*BURST and burstcount = BURST. Address, burstcount and read are held stable while waitrequest=1. -> WAIT_DATA on the cycle read && !waitrequest.
  - WAIT_DATA: each readdatavalid beat is written to the FIFO. After BURST beats, burst_idx is incremented.
    - If burst_idx reaches length: pulse buf_done_irq, move pending to active (or clear active), reset burst_idx, -> IDLE.
    - Else -> IDLE; the space check is re-evaluated there.
- Address arithmetic is 29-bit modulo; wrap past the top of the address space is not detected.
- Enable cleared mid-operation:
  - ISSUE not yet accepted: drop read immediately, -> IDLE.
  - WAIT_DATA: finish all BURST beats into the FIFO, then -> IDLE.
  - Active and pending slots are retained; fetching resumes at the same burst_idx on re-enable.
- Same cycle as buffer completion + buffer strobe: completion promotes pending first, then the strobe fills the freed slot. No address is lost and overrun is not set.
- Sample path:
  - A FIFO word supplies 4 samples, lanes [15:0], [31:16], [47:32], [63:48] in that order.
  - sample_req at cycle N produces sample_valid at N+1.
  - The FIFO pops after lane 3 is served.
  - sample_req with FIFO empty: sample_data=0, sample_valid=1, underflow set, lane index unchanged.
- busy = active valid OR FSM != IDLE.
- Reset mid-burst clears all state. The HPS port resets on the same rst, so no stray beats are expected.

Decomposition:
- Shared package (apu_pkg): BURST and FIFO_DEPTH defaults, the control-word bit positions, and the FSM state enum {IDLE, ISSUE, WAIT_DATA}.
- One sub-module: apu_sample_fifo, a synchronous 64-bit FIFO with a free-entry count output, used for the space check.

Test Plan:
- Length=1 burst, buf=0x1000_0000, enable: exactly one read with address 0x0200_0000 and burstcount 8. Feed 8 beats with lanes 0x0001..0x0020. 32 sample_req return 0x0001..0x0020 in order; buf_done_irq pulses once after beat 8.
- waitrequest held high for 5 cycles during ISSUE: address, burstcount and read stay stable; exactly one burst is accepted.
- Three buffer strobes while the first buffer is active: overrun=1; the third address is fetched after the first completes and the second is never read. Control bit 1 clears overrun.
- sample_req with empty FIFO: sample_data=0, underflow=1. The first sample after refill is lane 0 of the first word.
- Length=2, buffer completion coincides with a buffer strobe: second irq fires for the pending buffer; no overrun.
- Enable dropped on beat 3 of a burst: remaining 5 beats are accepted, no new read issues; on re-enable, the next read address is base+8.
